// File: rtl/dict_decompressor.sv
// Dictionary decompressor: expands a token stream of literals and dictionary keys into
// LANES-wide output words, with one word held in a registered valid/ready output stage.
module dict_decompressor #(
    parameter int unsigned KEY_WIDTH = 4,
    parameter int unsigned VAL_WIDTH = 8,
    parameter int unsigned LANES     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_is_key,
    input  logic [VAL_WIDTH-1:0]       in_data,
    input  logic                       in_last,
    output logic [KEY_WIDTH-1:0]       dict_key_out,
    input  logic [VAL_WIDTH-1:0]       dict_val_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*VAL_WIDTH-1:0] out_data,
    output logic                       out_last,
    output logic [15:0]                word_count,
    output logic [15:0]                key_count
);

    localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned WordW = LANES * VAL_WIDTH;

    logic [LaneW-1:0]     lane_q, lane_d;
    logic [WordW-1:0]     asm_q, asm_d;
    logic [WordW-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [15:0]          word_cnt_q, word_cnt_d;
    logic [15:0]          key_cnt_q, key_cnt_d;

    logic                 accept;
    logic                 out_hs;
    logic                 complete;
    logic [VAL_WIDTH-1:0] value;
    logic [WordW-1:0]     filled;

    assign dict_key_out = in_data[KEY_WIDTH-1:0];
    assign in_ready     = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign out_hs       = out_valid_q && out_ready;
    assign value        = in_is_key ? dict_val_in : in_data;
    assign complete     = accept && ((lane_q == LaneW'(LANES - 1)) || in_last);

    always_comb begin
        filled = asm_q;
        filled[int'(lane_q)*VAL_WIDTH +: VAL_WIDTH] = value;

        lane_d      = lane_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q + (out_hs ? 16'd1 : 16'd0);
        key_cnt_d   = key_cnt_q + ((accept && in_is_key) ? 16'd1 : 16'd0);

        if (out_hs) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                // A completing accept reloads the output even in a handshake cycle.
                lane_d      = '0;
                asm_d       = '0;
                out_data_d  = filled;
                out_last_d  = in_last;
                out_valid_d = 1'b1;
            end else begin
                lane_d = lane_q + LaneW'(1);
                asm_d  = filled;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q      <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
            key_cnt_q   <= '0;
        end else begin
            lane_q      <= lane_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
            key_cnt_q   <= key_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign word_count = word_cnt_q;
    assign key_count  = key_cnt_q;

endmodule

// File: tb/tb_dict_decompressor.sv
// Directed bench for dict_decompressor: table of tokens with expected words, then
// hand-written backpressure and mid-word reset sequences.
module tb_dict_decompressor;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_key;
    logic [7:0]  in_data;
    logic        in_last;
    logic [3:0]  dict_key_out;
    logic [7:0]  dict_val_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [15:0] word_count;
    logic [15:0] key_count;

    int checks = 0;
    int errors = 0;

    dict_decompressor dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_key    (in_is_key),
        .in_data      (in_data),
        .in_last      (in_last),
        .dict_key_out (dict_key_out),
        .dict_val_in  (dict_val_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .word_count   (word_count),
        .key_count    (key_count)
    );

    always #5 clk = ~clk;

    // Dictionary model: dict[k] = 8'hA0 + k
    always_comb dict_val_in = 8'hA0 + {4'h0, dict_key_out};

    typedef struct {
        logic        is_key;
        logic [7:0]  data;
        logic        last;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic is_key, input logic [7:0] data, input logic last);
        in_valid  = 1'b1;
        in_is_key = is_key;
        in_data   = data;
        in_last   = last;
        step();
        in_valid  = 1'b0;
    endtask

    vec_t vecs[17];
    logic [31:0] held;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_is_key = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        out_ready = 1'b1;

        vecs[0]  = '{1'b0, 8'h11, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 8'h22, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 8'h33, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 8'h44, 1'b0, 1'b1, 32'h44332211, 1'b0};
        vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 8'h0F, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 8'h7E, 1'b0, 1'b1, 32'h7EAFA0A3, 1'b0};
        vecs[8]  = '{1'b0, 8'h55, 1'b1, 1'b1, 32'h00000055, 1'b1};
        vecs[9]  = '{1'b1, 8'hF2, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 8'h01, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 8'h02, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 8'h03, 1'b1, 1'b1, 32'h030201A2, 1'b1};
        vecs[13] = '{1'b0, 8'h10, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[14] = '{1'b0, 8'h20, 1'b1, 1'b1, 32'h00002010, 1'b1};
        vecs[15] = '{1'b1, 8'h01, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 8'hC3, 1'b1, 1'b1, 32'h0000C3A1, 1'b1};

        step();
        step();
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_last", {31'h0, out_last}, 32'h0);
        chk("reset word_count", {16'h0, word_count}, 32'h0);
        chk("reset key_count", {16'h0, key_count}, 32'h0);
        reset = 1'b0;

        // Combinational key lookup, upper key bits ignored
        in_is_key = 1'b1;
        in_data   = 8'hF2;
        #1;
        chk("dict_key_out F2", {28'h0, dict_key_out}, 32'h2);
        chk("in_ready idle", {31'h0, in_ready}, 32'h1);
        step();

        for (int i = 0; i < 17; i++) begin
            send(vecs[i].is_key, vecs[i].data, vecs[i].last);
            chk($sformatf("vec%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
                chk($sformatf("vec%0d out_last", i), {31'h0, out_last}, {31'h0, vecs[i].exp_last});
            end
        end
        step();
        chk("word_count after table", {16'h0, word_count}, 32'd6);
        chk("key_count after table", {16'h0, key_count}, 32'd5);
        chk("out_valid drained", {31'h0, out_valid}, 32'h0);

        // Backpressure: pending word held, input stalled
        send(1'b0, 8'h81, 1'b0);
        send(1'b0, 8'h82, 1'b0);
        send(1'b0, 8'h83, 1'b0);
        send(1'b0, 8'h84, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_is_key = 1'b0;
        in_data   = 8'h91;
        in_last   = 1'b0;
        #1;
        held = 32'h84838281;
        chk("stall in_ready", {31'h0, in_ready}, 32'h0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("stall%0d out_data", c), out_data, held);
            chk($sformatf("stall%0d out_valid", c), {31'h0, out_valid}, 32'h1);
        end
        chk("stall word_count", {16'h0, word_count}, 32'd6);
        out_ready = 1'b1;
        send(1'b0, 8'h91, 1'b0);
        chk("release handshake", {16'h0, word_count}, 32'd7);
        chk("release out_valid", {31'h0, out_valid}, 32'h0);
        send(1'b0, 8'h92, 1'b0);
        send(1'b0, 8'h93, 1'b0);
        send(1'b0, 8'h94, 1'b0);
        chk("resume out_data", out_data, 32'h94939291);
        chk("resume out_valid", {31'h0, out_valid}, 32'h1);

        // Reset mid-word with a pending output and a token on the input
        send(1'b0, 8'h5A, 1'b0);
        send(1'b0, 8'h5B, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("midreset out_valid", {31'h0, out_valid}, 32'h0);
        chk("midreset out_data", out_data, 32'h0);
        chk("midreset word_count", {16'h0, word_count}, 32'h0);
        chk("midreset key_count", {16'h0, key_count}, 32'h0);
        send(1'b0, 8'h01, 1'b0);
        send(1'b0, 8'h02, 1'b0);
        send(1'b0, 8'h03, 1'b0);
        send(1'b0, 8'h04, 1'b0);
        chk("post-reset out_data", out_data, 32'h04030201);
        chk("post-reset out_last", {31'h0, out_last}, 32'h0);
        step();
        chk("post-reset word_count", {16'h0, word_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
